// File: rtl/hwpe_stream_interleave_pkg.sv
// Shared types for the stream interleaver: the FSM state
// encoding and the latched job configuration.
package hwpe_stream_package;

  localparam int CFG_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SRC0,
    SRC1,
    DONE
  } interleave_state_t;

  // Lengths are zero-extended into CFG_W-bit fields
  // (counter widths up to CFG_W are supported).
  typedef struct packed {
    logic [CFG_W-1:0] len0;
    logic [CFG_W-1:0] len1;
    logic [CFG_W-1:0] rounds;
  } interleave_cfg_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Valid/ready stream bundle: data, byte strobe, handshake.
// sink = consumer view, source = producer view.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

endinterface

// File: rtl/hwpe_stream_interleave_ctrl.sv
// Interleaver control: IDLE/SRC0/SRC1/DONE FSM, beat and round counters.
// Ports: clk_i, rst_i, start_i, len0_i, len1_i, rounds_i (job config);
// vld0_i, vld1_i (input valids), accept_i (output stage can take a beat),
// empty_i (output stage drained); en_o, sel_o (source select),
// take0_o, take1_o (beat-consumed strobes), busy_o, done_o.
module hwpe_stream_interleave_ctrl #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len0_i,
  input  logic [CNT_WIDTH-1:0] len1_i,
  input  logic [CNT_WIDTH-1:0] rounds_i,
  input  logic                 vld0_i,
  input  logic                 vld1_i,
  input  logic                 accept_i,
  input  logic                 empty_i,
  output logic                 en_o,
  output logic                 sel_o,
  output logic                 take0_o,
  output logic                 take1_o,
  output logic                 busy_o,
  output logic                 done_o
);
  import hwpe_stream_package::*;

  interleave_state_t st_q, st_d;
  interleave_cfg_t   cfg_q, cfg_d;

  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic [CNT_WIDTH-1:0] rnd_q, rnd_d;

  logic [CFG_W-1:0] beat_nx;
  logic [CFG_W-1:0] rnd_nx;
  logic             last0;
  logic             last1;
  logic             rlast;

  // Compare count+1 against the latched length so the
  // counters stop at length-1 and never wrap.
  assign beat_nx = CFG_W'(beat_q) + CFG_W'(1);
  assign rnd_nx  = CFG_W'(rnd_q) + CFG_W'(1);
  assign last0   = (beat_nx == cfg_q.len0);
  assign last1   = (beat_nx == cfg_q.len1);
  assign rlast   = (rnd_nx == cfg_q.rounds);

  assign en_o    = (st_q == SRC0) || (st_q == SRC1);
  assign sel_o   = (st_q == SRC1);
  assign take0_o = (st_q == SRC0) && vld0_i && accept_i;
  assign take1_o = (st_q == SRC1) && vld1_i && accept_i;
  assign busy_o  = (st_q != IDLE);
  assign done_o  = (st_q == DONE) && empty_i;

  always_comb begin
    st_d   = st_q;
    cfg_d  = cfg_q;
    beat_d = beat_q;
    rnd_d  = rnd_q;
    unique case (st_q)
      IDLE: begin
        if (start_i) begin
          cfg_d.len0   = CFG_W'(len0_i);
          cfg_d.len1   = CFG_W'(len1_i);
          cfg_d.rounds = CFG_W'(rounds_i);
          beat_d       = '0;
          rnd_d        = '0;
          if (rounds_i == '0 ||
              (len0_i == '0 && len1_i == '0))
            st_d = DONE;
          else if (len0_i == '0)
            st_d = SRC1;
          else
            st_d = SRC0;
        end
      end
      SRC0: begin
        if (take0_o) begin
          if (last0) begin
            beat_d = '0;
            if (cfg_q.len1 == '0) begin
              rnd_d = rnd_q + 1'b1;
              st_d  = rlast ? DONE : SRC0;
            end else begin
              st_d = SRC1;
            end
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      SRC1: begin
        if (take1_o) begin
          if (last1) begin
            beat_d = '0;
            rnd_d  = rnd_q + 1'b1;
            if (rlast)
              st_d = DONE;
            else if (cfg_q.len0 == '0)
              st_d = SRC1;
            else
              st_d = SRC0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (empty_i)
          st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= IDLE;
      cfg_q  <= '0;
      beat_q <= '0;
      rnd_q  <= '0;
    end else begin
      st_q   <= st_d;
      cfg_q  <= cfg_d;
      beat_q <= beat_d;
      rnd_q  <= rnd_d;
    end
  end

endmodule

// File: rtl/hwpe_stream_interleave.sv
// Interleaves len0 beats of in0 with len1 beats of in1, rounds times.
// Ports: clk_i, rst_i, start_i, len0_i, len1_i, rounds_i, busy_o, done_o,
// in0/in1 (stream sinks), out (stream source).
// HWPE_STREAM_INTERLEAVE_OUTREG_EN: one-entry output register (1-cycle
// latency); otherwise the output is a combinational pass-through.
module hwpe_stream_interleave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len0_i,
  input  logic [CNT_WIDTH-1:0] len1_i,
  input  logic [CNT_WIDTH-1:0] rounds_i,
  output logic                 busy_o,
  output logic                 done_o,
  hwpe_stream_intf_stream.sink   in0,
  hwpe_stream_intf_stream.sink   in1,
  hwpe_stream_intf_stream.source out
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  en;
  logic                  sel;
  logic                  take0;
  logic                  take1;
  logic                  accept;
  logic                  empty;
  logic                  mux_vld;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [STRB_W-1:0]     mux_strb;

  assign mux_vld  = sel ? in1.valid : in0.valid;
  assign mux_data = sel ? in1.data  : in0.data;
  assign mux_strb = sel ? in1.strb  : in0.strb;

  assign in0.ready = en && !sel && accept;
  assign in1.ready = en &&  sel && accept;

  hwpe_stream_interleave_ctrl #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .len0_i   (len0_i),
    .len1_i   (len1_i),
    .rounds_i (rounds_i),
    .vld0_i   (in0.valid),
    .vld1_i   (in1.valid),
    .accept_i (accept),
    .empty_i  (empty),
    .en_o     (en),
    .sel_o    (sel),
    .take0_o  (take0),
    .take1_o  (take1),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

`ifdef HWPE_STREAM_INTERLEAVE_OUTREG_EN
  logic                  take;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]     strb_q;

  assign take   = take0 || take1;
  assign accept = !vld_q || out.ready;
  assign empty  = !vld_q;

  // Held beat stays put until out.ready; refill in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      strb_q <= '0;
    end else begin
      if (accept)
        vld_q <= take;
      if (take) begin
        data_q <= mux_data;
        strb_q <= mux_strb;
      end
    end
  end

  assign out.valid = vld_q;
  assign out.data  = data_q;
  assign out.strb  = strb_q;
`else
  logic unused_take;

  assign unused_take = take0 ^ take1;
  assign accept      = out.ready;
  assign empty       = 1'b1;
  assign out.valid   = en && mux_vld;
  assign out.data    = mux_data;
  assign out.strb    = mux_strb;
`endif

endmodule

// File: tb/tb_hwpe_stream_interleave.sv
// Directed bench for hwpe_stream_interleave: beat order, stall hold,
// done timing, zero-length jobs, reset abort, ignored start.
module tb_hwpe_stream_interleave;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] l0, l1, rn;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int idx0, idx1;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in0_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) in1_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) out_if ();

  hwpe_stream_interleave #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .len0_i   (l0),
    .len1_i   (l1),
    .rounds_i (rn),
    .busy_o   (busy),
    .done_o   (done),
    .in0      (in0_if),
    .in1      (in1_if),
    .out      (out_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    in0_if.valid = 1'b1;
    in0_if.data  = 32'hA000_0000 + idx0;
    in0_if.strb  = 4'h3;
    in1_if.valid = 1'b1;
    in1_if.data  = 32'hB000_0000 + idx1;
    in1_if.strb  = 4'hC;
  endtask

  task automatic run_job(input string nm,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         input logic [15:0] r,
                         input bit tgl,
                         input int spur,
                         output bit r0_ever,
                         output bit ov_ever);
    logic [35:0] got[$];
    logic [35:0] exp[$];
    logic [35:0] held;
    int ia, ib, cyc, done_n, done_cyc, last_ho, left, n;
    bit h0, h1, ho, stall;
    ia = 0;
    ib = 0;
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < a; i++) begin
        exp.push_back({4'h3, 32'hA000_0000 + ia});
        ia++;
      end
      for (int i = 0; i < b; i++) begin
        exp.push_back({4'hC, 32'hB000_0000 + ib});
        ib++;
      end
    end
    idx0 = 0;
    idx1 = 0;
    drive_src();
    out_if.ready = 1'b1;
    l0 = a;
    l1 = b;
    rn = r;
    start = 1'b1;
    r0_ever = 0;
    ov_ever = 0;
    done_n = 0;
    done_cyc = -1;
    last_ho = -1;
    left = -1;
    cyc = 0;
    stall = 0;
    held = '0;
    while (cyc < 200 && left != 0) begin
      @(negedge clk);
      if (stall)
        chk({nm, " hold"},
            {27'd0, out_if.valid, out_if.strb, out_if.data},
            {27'd0, 1'b1, held});
      h0 = in0_if.valid && in0_if.ready;
      h1 = in1_if.valid && in1_if.ready;
      ho = out_if.valid && out_if.ready;
      if (in0_if.ready) r0_ever = 1;
      if (out_if.valid) ov_ever = 1;
      if (ho) begin
        got.push_back({out_if.strb, out_if.data});
        last_ho = cyc;
      end
      stall = out_if.valid && !out_if.ready;
      held  = {out_if.strb, out_if.data};
      if (done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (done_n > 0 && left < 0) left = 3;
      @(posedge clk);
      #1;
      if (left > 0) left--;
      start = 1'b0;
      if (cyc + 1 == spur) begin
        start = 1'b1;
        l0 = 16'd5;
        l1 = 16'd5;
        rn = 16'd5;
      end
      if (h0) idx0++;
      if (h1) idx1++;
      drive_src();
      if (tgl) out_if.ready = ~out_if.ready;
      cyc++;
    end
    chk({nm, " finished"}, 64'(done_n > 0), 64'd1);
    chk({nm, " beats"}, 64'(got.size()), 64'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s beat%0d", nm, i), 64'(got[i]), 64'(exp[i]));
    chk({nm, " done pulses"}, 64'(done_n), 64'd1);
    if (exp.size() > 0)
      chk({nm, " done timing"}, 64'(done_cyc), 64'(last_ho + 1));
    chk({nm, " busy end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit r0e, ove;
    rst = 1'b1;
    start = 1'b0;
    l0 = '0;
    l1 = '0;
    rn = '0;
    idx0 = 0;
    idx1 = 0;
    drive_src();
    out_if.ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst ovalid", 64'(out_if.valid), 64'd0);
    chk("rst rdy0", 64'(in0_if.ready), 64'd0);
    chk("rst rdy1", 64'(in1_if.ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_job("j1", 16'd2, 16'd3, 16'd2, 1'b0, -1, r0e, ove);
    run_job("j2", 16'd0, 16'd4, 16'd1, 1'b0, -1, r0e, ove);
    chk("j2 rdy0 never", 64'(r0e), 64'd0);
    run_job("j3a", 16'd3, 16'd2, 16'd0, 1'b0, -1, r0e, ove);
    chk("j3a ovalid never", 64'(ove), 64'd0);
    run_job("j3b", 16'd0, 16'd0, 16'd3, 1'b0, -1, r0e, ove);
    chk("j3b ovalid never", 64'(ove), 64'd0);
    run_job("j4", 16'd1, 16'd1, 16'd4, 1'b1, -1, r0e, ove);
    run_job("j5", 16'd2, 16'd3, 16'd2, 1'b0, 3, r0e, ove);
    run_job("j7", 16'd2, 16'd0, 16'd2, 1'b0, -1, r0e, ove);

    idx0 = 0;
    idx1 = 0;
    drive_src();
    out_if.ready = 1'b1;
    l0 = 16'd1;
    l1 = 16'd4;
    rn = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid busy", 64'(busy), 64'd1);
    chk("mid rdy1", 64'(in1_if.ready), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort ovalid", 64'(out_if.valid), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    chk("abort rdy0", 64'(in0_if.ready), 64'd0);
    chk("abort rdy1", 64'(in1_if.ready), 64'd0);
    run_job("j6", 16'd3, 16'd1, 16'd2, 1'b0, -1, r0e, ove);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
